// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: client request bus plus MCB cmd/wr/rd FIFO port of the arbiter
interface mem_port_arbiter_if #(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 18,
    parameter int BURST_MAX = 16
);
    localparam int LEN_W = $clog2(BURST_MAX + 1);
    logic                  calib_done;
    logic [NCH-1:0]        req, req_wren, wr_take, rd_valid, ack;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH*LEN_W-1:0]  req_len;
    logic [NCH*32-1:0]     req_wdata;
    logic [31:0]           rdata;
    logic                  cmd_en, cmd_full;
    logic [2:0]            cmd_instr;
    logic [5:0]            cmd_bl;
    logic [29:0]           cmd_byte_addr;
    logic                  wr_en, wr_full, wr_empty, wr_underrun;
    logic [31:0]           wr_data;
    logic [3:0]            wr_mask;
    logic                  rd_en, rd_empty, rd_overflow;
    logic [31:0]           rd_data;
    logic                  busy, err;
    logic [3:0]            state_dbg;

    modport slave (
        input  calib_done, req, req_wren, req_addr, req_len, req_wdata,
        input  cmd_full, wr_full, wr_empty, wr_underrun, rd_data, rd_empty, rd_overflow,
        output wr_take, rdata, rd_valid, ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        output wr_en, wr_data, wr_mask, rd_en, busy, err, state_dbg
    );
    modport master (
        output calib_done, req, req_wren, req_addr, req_len, req_wdata,
        output cmd_full, wr_full, wr_empty, wr_underrun, rd_data, rd_empty, rd_overflow,
        input  wr_take, rdata, rd_valid, ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        input  wr_en, wr_data, wr_mask, rd_en, busy, err, state_dbg
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter of NCH burst clients onto one LPDDR MCB user port; define MEM_ARB_WRITE_FLUSH_EN to hold write ack until the MCB write FIFO drains
module mem_port_arbiter #(
    parameter int NCH        = 2,
    parameter int ADDR_W     = 18,
    parameter int ADDR_SHIFT = 3,
    parameter int BURST_MAX  = 16
) (
    input  logic              modified_clock_sram_i,
    input  logic              ddr_core_rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int LEN_W = $clog2(BURST_MAX + 1);
    localparam int GW    = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        IDLE     = 4'd1,
        WR_FILL  = 4'd2,
        WR_CMD   = 4'd3,
        WR_FLUSH = 4'd4,
        RD_CMD   = 4'd5,
        RD_DATA  = 4'd6,
        DONE     = 4'd7
    } state_t;

    state_t            state_q;
    logic [GW-1:0]     g_q, last_q, pick_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q, cnt_q, len_d, rl_d;
    logic [NCH-1:0]    rd_valid_q, ack_q, req_m, rot_d, g_oh;
    logic [31:0]       rdata_q;
    logic              err_q, wr_go, cmd_go, rd_go;
    logic [63:0]       byte_addr;

    // Round-robin pick: rotate so bit 0 is the channel after last_grant, take the lowest set bit.
    // A request whose ack is on the bus this cycle is its old request still held, so it is masked.
    always_comb begin
        int off;
        off   = 0;
        req_m = bus.req & ~ack_q;
        rot_d = NCH'({req_m, req_m} >> (int'(last_q) + 1));
        for (int k = NCH - 1; k >= 0; k--) if (rot_d[k]) off = k;
        pick_d = GW'((int'(last_q) + 1 + off) % NCH);
        rl_d   = bus.req_len[pick_d*LEN_W +: LEN_W];
        len_d  = rl_d == '0 ? LEN_W'(1) : (rl_d > LEN_W'(BURST_MAX) ? LEN_W'(BURST_MAX) : rl_d);
    end

    assign g_oh      = NCH'(1) << g_q;
    assign byte_addr = 64'(addr_q) << ADDR_SHIFT;
    assign wr_go     = state_q == WR_FILL && !bus.wr_full;
    assign cmd_go    = (state_q == WR_CMD || state_q == RD_CMD) && !bus.cmd_full;
    assign rd_go     = state_q == RD_DATA && !bus.rd_empty;

    assign bus.cmd_en        = cmd_go;
    assign bus.cmd_instr     = {2'b00, state_q == RD_CMD};
    assign bus.cmd_bl        = 6'(len_q - LEN_W'(1));
    assign bus.cmd_byte_addr = byte_addr[29:0];
    assign bus.wr_en         = wr_go;
    assign bus.wr_data       = bus.req_wdata[g_q*32 +: 32];
    assign bus.wr_mask       = 4'd0;
    assign bus.wr_take       = wr_go ? g_oh : '0;
    assign bus.rd_en         = rd_go;
    assign bus.rdata         = rdata_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.ack           = ack_q;
    assign bus.err           = err_q;
    // INIT counts as not busy so that everything reads 0 until calibration completes.
    assign bus.busy          = !(state_q == IDLE || state_q == INIT);
    assign bus.state_dbg     = state_q;

    // Transaction FSM with the registered read-data, pulse and sticky error outputs.
    always_ff @(posedge modified_clock_sram_i) begin
        if (ddr_core_rst_i) begin
            state_q    <= INIT;
            last_q     <= GW'(NCH - 1);
            g_q        <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            ack_q      <= '0;
            err_q      <= err_q | bus.wr_underrun | bus.rd_overflow;
            case (state_q)
                INIT: if (bus.calib_done) state_q <= IDLE;
                IDLE: if (|req_m) begin
                    g_q     <= pick_d;
                    addr_q  <= bus.req_addr[pick_d*ADDR_W +: ADDR_W];
                    len_q   <= len_d;
                    cnt_q   <= len_d;
                    state_q <= bus.req_wren[pick_d] ? WR_FILL : RD_CMD;
                end
                WR_FILL: if (wr_go) begin
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_q <= WR_CMD;
                end
`ifdef MEM_ARB_WRITE_FLUSH_EN
                WR_CMD: if (cmd_go) state_q <= WR_FLUSH;
`else
                WR_CMD: if (cmd_go) state_q <= DONE;
`endif
                WR_FLUSH: if (bus.wr_empty) state_q <= DONE;
                RD_CMD: if (cmd_go) state_q <= RD_DATA;
                RD_DATA: if (rd_go) begin
                    rdata_q    <= bus.rd_data;
                    rd_valid_q <= g_oh;
                    cnt_q      <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= g_oh;
                    last_q  <= g_q;
                    state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a small MCB/client model
module tb_mem_port_arbiter;
    localparam int NCH = 2, ADDR_W = 18, BURST_MAX = 16, LEN_W = 5;

    typedef struct packed {
        logic [NCH-1:0] oh;
        logic [31:0]    d;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NCH(NCH), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) bus ();
    mem_port_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .ADDR_SHIFT(3), .BURST_MAX(BURST_MAX)) dut (
        .modified_clock_sram_i(clk),
        .ddr_core_rst_i(rst),
        .bus(bus)
    );

    int total = 0, bad = 0, wr_seen = 0;
    logic mon_on = 1'b0;
    ev_t  exp_w[$], exp_r[$];
    logic [38:0] exp_cmd[$];
    logic [NCH-1:0] exp_ack[$];
    ev_t me;
    logic [38:0] mc;
    logic [NCH-1:0] ma;

    logic [31:0] wdat[NCH][32];
    logic [4:0]  widx[NCH];
    logic [31:0] rd_mem[64];
    int rd_wp = 0, rd_rp = 0;

    assign bus.req_wdata = {wdat[1][widx[1]], wdat[0][widx[0]]};
    assign bus.rd_empty  = rd_rp == rd_wp;
    assign bus.rd_data   = rd_mem[rd_rp[5:0]];
    always @(posedge clk) if (bus.rd_en === 1'b1) rd_rp <= rd_rp + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT produces a write word, command, read word or ack.
    always @(negedge clk) if (mon_on) begin
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            if (exp_w.size() == 0) check("wr_unexpected", 64'(bus.wr_data), 64'hDEAD);
            else begin
                me = exp_w.pop_front();
                check("wr_data", 64'(bus.wr_data), 64'(me.d));
                check("wr_take", 64'(bus.wr_take), 64'(me.oh));
            end
        end else check("wr_take_idle", 64'(bus.wr_take), 64'd0);
        if (bus.cmd_en === 1'b1) begin
            if (exp_cmd.size() == 0) check("cmd_unexpected", 64'(bus.cmd_byte_addr), 64'hDEAD);
            else begin
                mc = exp_cmd.pop_front();
                check("cmd", 64'({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}), 64'(mc));
            end
        end
        if (bus.rd_valid !== '0) begin
            if (exp_r.size() == 0) check("rd_unexpected", 64'(bus.rdata), 64'hDEAD);
            else begin
                me = exp_r.pop_front();
                check("rd", 64'({bus.rd_valid, bus.rdata}), 64'({me.oh, me.d}));
            end
        end
        if (bus.ack !== '0) begin
            if (exp_ack.size() == 0) check("ack_unexpected", 64'(bus.ack), 64'd0);
            else begin
                ma = exp_ack.pop_front();
                check("ack", 64'(bus.ack), 64'(ma));
            end
        end
    end

    function automatic int eff_len(input int len);
        return len == 0 ? 1 : (len > BURST_MAX ? BURST_MAX : len);
    endfunction

    task automatic step();
        logic [NCH-1:0] wt;
        @(negedge clk);
        wt = bus.wr_take;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (wt[c]) widx[c] = widx[c] + 5'd1;
            if (bus.ack[c]) bus.req[c] = 1'b0;
        end
    endtask

    task automatic issue(input int c, input logic wr, input logic [17:0] addr, input int len, input logic [31:0] base);
        int n;
        logic [NCH-1:0] oh;
        logic [29:0] ba;
        n  = eff_len(len);
        oh = NCH'(1) << c;
        ba = 30'({12'd0, addr} << 3);
        for (int i = 0; i < n; i++) begin
            if (wr) begin
                wdat[c][i] = base + 32'(i);
                exp_w.push_back({oh, base + 32'(i)});
            end else begin
                rd_mem[rd_wp[5:0]] = base * 32'(i + 1);
                rd_wp++;
                exp_r.push_back({oh, base * 32'(i + 1)});
            end
        end
        exp_cmd.push_back({2'b00, !wr, 6'(n - 1), ba});
        exp_ack.push_back(oh);
        widx[c] = 5'd0;
        bus.req_wren[c] = wr;
        bus.req_addr[c*ADDR_W +: ADDR_W] = addr;
        bus.req_len[c*LEN_W +: LEN_W] = LEN_W'(len);
        bus.req[c] = 1'b1;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (exp_ack.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check(tag, 64'(exp_ack.size() + exp_w.size() + exp_r.size() + exp_cmd.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.busy, bus.cmd_en, bus.wr_en, bus.rd_en, bus.err, bus.ack, bus.rd_valid, bus.wr_take, bus.rdata});
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        bus.calib_done = 1'b0;
        bus.req = '0;
        bus.req_wren = '0;
        bus.req_addr = '0;
        bus.req_len = '0;
        bus.cmd_full = 1'b0;
        bus.wr_full = 1'b0;
        bus.wr_empty = 1'b1;
        bus.wr_underrun = 1'b0;
        bus.rd_overflow = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            widx[c] = 5'd0;
            for (int i = 0; i < 32; i++) wdat[c][i] = 32'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        step();
        check("init_state", 64'(bus.state_dbg), 64'd0);
        check("init_outs", outs(), 64'd0);
        bus.calib_done = 1'b1;
        step();
        check("idle_state", 64'(bus.state_dbg), 64'd1);
        check("idle_outs", outs(), 64'd0);

        bus.wr_empty = 1'b0;
        issue(0, 1'b1, 18'h00010, 4, 32'hA0);
        repeat (10) step();
`ifdef MEM_ARB_WRITE_FLUSH_EN
        check("flush_state", 64'(bus.state_dbg), 64'd4);
        check("flush_hold_ack", 64'(exp_ack.size()), 64'd1);
`else
        check("posted_ack", 64'(exp_ack.size()), 64'd0);
`endif
        bus.wr_empty = 1'b1;
        wait_done(20, "wr_done");
        check("wr_count", 64'(wr_seen), 64'd4);

        bus.cmd_full = 1'b1;
        issue(1, 1'b0, 18'h00020, 2, 32'h11111111);
        repeat (3) begin
            step();
            check("cmd_stall_en", 64'(bus.cmd_en), 64'd0);
            check("cmd_stall_state", 64'(bus.state_dbg), 64'd5);
        end
        bus.cmd_full = 1'b0;
        wait_done(20, "rd_done");

        do_reset();
        issue(0, 1'b1, 18'h00100, 2, 32'hB0);
        issue(1, 1'b0, 18'h00104, 3, 32'h01010101);
        wait_done(40, "rr_first");
        issue(0, 1'b0, 18'h00003, 0, 32'h5A5A5A5A);
        wait_done(20, "len0_read");
        issue(1, 1'b0, 18'h00200, 1, 32'h0F0F0F0F);
        issue(0, 1'b1, 18'h00300, 3, 32'hC0);
        wait_done(40, "rr_second");

        issue(1, 1'b1, 18'h3FFFF, 31, 32'hD0);
        base = wr_seen;
        n = 0;
        while (wr_seen < base + 3 && n < 20) begin
            step();
            n++;
        end
        bus.wr_full = 1'b1;
        repeat (5) begin
            step();
            check("stall_wr_en", 64'(bus.wr_en), 64'd0);
            check("stall_wr_take", 64'(bus.wr_take), 64'd0);
            check("stall_state", 64'(bus.state_dbg), 64'd2);
        end
        bus.wr_full = 1'b0;
        wait_done(60, "stall_done");
        check("stall_count", 64'(wr_seen - base), 64'd16);

        check("err_clear", 64'(bus.err), 64'd0);
        bus.rd_overflow = 1'b1;
        step();
        bus.rd_overflow = 1'b0;
        check("err_set", 64'(bus.err), 64'd1);
        repeat (4) step();
        check("err_sticky", 64'(bus.err), 64'd1);
        do_reset();
        check("err_reset", 64'(bus.err), 64'd0);
        check("reset_state", 64'(bus.state_dbg), 64'd0);
        step();
        check("scoreboard_empty", 64'(exp_ack.size() + exp_w.size() + exp_r.size() + exp_cmd.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
